float2uchar: RTL and testbench
==============================

// Module: float2uchar
// PURPOSE
//  Iterative IEEE-754 single (S/E/F fields) to 8-bit unsigned converter; the
//  inverse of the byte-to-float path. Sits on the output side of the float
//  datapath: pixel/score floats are converted back to 0-255 bytes.
//  Valid/ready on both sides; one conversion in flight; serial bit-shifter.
// PARAMETERS
//  ROUND  1  1 = round half up on the last bit shifted out; 0 = truncate
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  in_valid   in   1   S/E/F operand valid
//  in_ready   out  1   converter idle, operand is accepted this cycle
//  in_s       in   1   sign bit
//  in_e       in   8   biased exponent
//  in_f       in   23  mantissa fraction (hidden bit not included)
//  out_valid  out  1   out_d/out_flags valid, held until out_ready
//  out_ready  in   1   consumer takes the result
//  out_d      out  8   unsigned result 0..255
//  out_flags  out  3   {nan, sat, neg}: NaN input, clipped to 255, negative clamped to 0
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, out_d=0, out_flags=0,
//   shift register and counter cleared. Reset mid-operation discards the
//   conversion; no result is produced for it.
//  Accept: in_valid & in_ready at a rising edge. in_ready=1 only in IDLE.
//  Classification at accept (priority order):
//   E=255,F!=0 -> d=0,   flags=100
//   S=1        -> d=0,   flags=001 (includes -0, -Inf, negative denormals)
//   E=255,F=0  -> d=255, flags=010 (+Inf)
//   E>=135     -> d=255, flags=010
//   E<=125     -> d=0,   flags=000 (+0, denormals, values < 0.5)
//   E=126..134 -> shift path, N = 150-E (16..24)
//  Special cases: go straight to HOLD; out_valid is high the cycle after accept.
//  FSM states IDLE, SHIFT, ROUND, HOLD.
//   IDLE : on accept, load mant={1,F} (24b), cnt=N, guard=0; go to SHIFT.
//   SHIFT: each cycle mant<=mant>>1, guard<=mant[0], cnt<=cnt-1;
//          when cnt reaches 0 (after N shifts) go to ROUND.
//   ROUND: r = mant[8:0] + (ROUND ? guard : 0) (9b). If r>255 then d=255 and
//          sat=1, else d=r[7:0]. Go to HOLD.
//   HOLD : out_valid=1; out_d/out_flags stable. out_ready=1 -> IDLE.
//  Latency, shift path: accept at edge t0, out_valid asserted after edge
//   t0+N+1 (N SHIFT cycles plus 1 ROUND cycle). After the SHIFT phase,
//   mant[23:8]=0 for every legal E.
//  Throughput: no new accept in the cycle the result leaves HOLD. in_ready
//   rises the cycle after out_valid&out_ready.
//  out_valid is held with stable data under backpressure. in_* inputs are
//   don't-care outside accept cycles and are never re-sampled.
//  out_d/out_flags hold their last value in IDLE/SHIFT/ROUND. Only HOLD data
//   is meaningful.
// TESTING
//  200.0 (S=0,E=134,F=0x480000) -> out_d=200, flags=000, out_valid 17 cycles after accept
//  0.5 (E=126,F=0): ROUND=1 -> 1, ROUND=0 -> 0; 255.5 (E=134,F=0x7F8000), ROUND=1 -> 255, flags=010
//  300.0 (E=135,F=0x160000) -> 255/010; -3.0 (S=1,E=128,F=0x400000) -> 0/001; NaN (E=255,F=1) -> 0/100
//  +0, denormal (E=0,F=5), +Inf -> 0/000, 0/000, 255/010, each out_valid 1 cycle after accept
//  out_ready low for 5 cycles in HOLD -> out_valid and out_d stable, in_ready=0 throughout
//  rst asserted mid-SHIFT -> out_valid=0 immediately, in_ready=1; next accept (1.0, E=127) -> 1

Source files
------------

// File: rtl/float2uchar.sv
// IEEE-754 single (S/E/F) to 8-bit unsigned converter with a serial right shifter.
// One conversion in flight; valid/ready handshakes on both sides.
module float2uchar #(
  parameter int ROUND = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_s,
  input  logic [7:0]  in_e,
  input  logic [22:0] in_f,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_d,
  output logic [2:0]  out_flags
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_RND   = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]  r_state;
  logic [23:0] r_mant;
  logic        r_guard;
  logic [4:0]  r_cnt;

  logic        w_accept;
  logic        w_spec;
  logic [7:0]  w_spec_d;
  logic [2:0]  w_spec_flags;
  logic [7:0]  w_n8;
  logic [4:0]  w_n;
  logic        w_rnd_bit;
  logic [8:0]  w_sum;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_HOLD);
  assign w_accept  = in_valid && in_ready;

  // Shift count is 16..24 for the only exponents that reach the shifter (126..134).
  assign w_n8 = 8'd150 - in_e;
  assign w_n  = w_n8[4:0];

  // Value after the shifts is at most 255, so the sum can only reach 256 via rounding.
  assign w_rnd_bit = (ROUND != 0) && r_guard;
  assign w_sum     = r_mant[8:0] + {8'd0, w_rnd_bit};

  // Classification in priority order; anything not special takes the shift path.
  always_comb begin
    w_spec       = 1'b1;
    w_spec_d     = 8'd0;
    w_spec_flags = 3'b000;
    if (in_e == 8'hFF && in_f != 23'd0) begin
      w_spec_flags = 3'b100;
    end else if (in_s) begin
      w_spec_flags = 3'b001;
    end else if (in_e >= 8'd135) begin
      w_spec_d     = 8'hFF;
      w_spec_flags = 3'b010;
    end else if (in_e <= 8'd125) begin
      w_spec_d     = 8'd0;
    end else begin
      w_spec       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mant    <= 24'd0;
      r_guard   <= 1'b0;
      r_cnt     <= 5'd0;
      out_d     <= 8'd0;
      out_flags <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_spec) begin
              out_d     <= w_spec_d;
              out_flags <= w_spec_flags;
              r_state   <= S_HOLD;
            end else begin
              r_mant  <= {1'b1, in_f};
              r_cnt   <= w_n;
              r_guard <= 1'b0;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_mant  <= r_mant >> 1;
          r_guard <= r_mant[0];
          r_cnt   <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state <= S_RND;
          end
        end
        S_RND: begin
          if (w_sum > 9'd255) begin
            out_d     <= 8'hFF;
            out_flags <= 3'b010;
          end else begin
            out_d     <= w_sum[7:0];
            out_flags <= 3'b000;
          end
          r_state <= S_HOLD;
        end
        default: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float2uchar.sv
// Randomized bench for float2uchar: two instances (ROUND=1 and ROUND=0) on shared
// inputs, compared against a real-arithmetic reference model.
module tb_float2uchar;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_s;
  logic [7:0]  in_e;
  logic [22:0] in_f;
  logic        out_ready;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [7:0]  out_d1, out_d0;
  logic [2:0]  out_flags1, out_flags0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  float2uchar #(.ROUND(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_s(in_s), .in_e(in_e), .in_f(in_f),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_d(out_d1), .out_flags(out_flags1)
  );

  float2uchar #(.ROUND(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_s(in_s), .in_e(in_e), .in_f(in_f),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_d(out_d0), .out_flags(out_flags0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: value = 1.F * 2^(E-127) (or F * 2^-149 for denormals), rounded half up or truncated.
  function automatic void ref_conv(input logic s, input logic [7:0] e, input logic [22:0] f,
                                   input bit rnd, output int d, output int fl, output int lat);
    real v;
    int  k;
    lat = (!s && e >= 8'd126 && e <= 8'd134) ? (151 - int'(e)) : 0;
    if (e == 8'hFF && f != 23'd0) begin
      d = 0; fl = 4;
    end else if (s) begin
      d = 0; fl = 1;
    end else if (e == 8'hFF) begin
      d = 255; fl = 2;
    end else begin
      v = real'(int'(f));
      if (e != 8'd0) v = v + 8388608.0;
      k = (e == 8'd0) ? -149 : int'(e) - 150;
      while (k > 0) begin v = v * 2.0; k--; end
      while (k < 0) begin v = v / 2.0; k++; end
      if (rnd) v = v + 0.5;
      if (v >= 256.0) begin
        d = 255; fl = 2;
      end else begin
        d = $rtoi(v); fl = 0;
      end
    end
  endfunction

  task automatic conv(input logic s, input logic [7:0] e, input logic [22:0] f, input int stall);
    int d1, f1, d0, f0, lat, lat0, edges;
    logic [7:0] hold_d;
    ref_conv(s, e, f, 1'b1, d1, f1, lat);
    ref_conv(s, e, f, 1'b0, d0, f0, lat0);
    chk("in_ready_idle", {in_ready1, in_ready0}, 2'b11);
    in_s = s; in_e = e; in_f = f; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_s = 1'($urandom); in_e = 8'($urandom); in_f = 23'($urandom);
    edges = 0;
    while (!out_valid1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    chk("latency", edges, lat);
    chk("valid_pair", {out_valid1, out_valid0}, 2'b11);
    chk("d_r1", out_d1, d1);
    chk("flags_r1", out_flags1, f1);
    chk("d_r0", out_d0, d0);
    chk("flags_r0", out_flags0, f0);
    hold_d = out_d1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid1, 1'b1);
      chk("stall_d", out_d1, hold_d);
      chk("stall_ready", in_ready1, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release", {out_valid1, in_ready1}, 2'b01);
  endtask

  initial begin
    logic       rs;
    logic [7:0] re;
    logic [22:0] rf;
    rst = 1'b1; in_valid = 1'b0; in_s = 1'b0; in_e = 8'd0; in_f = 23'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", {in_ready1, out_valid1, out_d1, out_flags1}, {1'b1, 1'b0, 8'd0, 3'd0});
    rst = 1'b0;
    @(negedge clk);

    conv(1'b0, 8'd134, 23'h480000, 0);   // 200.0
    conv(1'b0, 8'd126, 23'h000000, 0);   // 0.5
    conv(1'b0, 8'd134, 23'h7F8000, 0);   // 255.5
    conv(1'b0, 8'd135, 23'h160000, 0);   // 300.0
    conv(1'b1, 8'd128, 23'h400000, 0);   // -3.0
    conv(1'b0, 8'd255, 23'h000001, 0);   // NaN
    conv(1'b0, 8'd0,   23'h000000, 0);   // +0
    conv(1'b0, 8'd0,   23'h000005, 0);   // denormal
    conv(1'b0, 8'd255, 23'h000000, 0);   // +Inf
    conv(1'b0, 8'd130, 23'h123456, 5);   // backpressure

    // Reset in the middle of the shift phase
    in_s = 1'b0; in_e = 8'd134; in_f = 23'h480000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst", {out_valid1, in_ready1, out_valid0, in_ready0}, 4'b0101);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    conv(1'b0, 8'd127, 23'h000000, 0);   // 1.0

    for (int n = 0; n < 150; n++) begin
      rs = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       re = 8'($urandom);
        1:       re = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
        default: re = 8'($urandom_range(124, 136));
      endcase
      rf = 23'($urandom);
      if ($urandom_range(0, 5) == 0) rf = 23'($urandom_range(0, 3)) << 14;
      conv(rs, re, rf, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
